bitblock_n: RTL and testbench
=============================

// Module: bitblock_n
// PURPOSE
//  Parametrised bit-serial MAC slice for the BC-MAC array. It generalises the single-lane bitblock to LANES weight lanes sharing one serial activation bit.
//  Activation x is streamed LSB-first, one bit per accepted cycle. Each lane accumulates w*x into its own ACC_W accumulator.
//  Supports signed or unsigned mode, multi-pass accumulation and wrap or saturate overflow. Weights are forwarded on yo for systolic chaining.
// PARAMETERS
//  W      4   weight width per lane
//  XBITS  8   activation bits per pass (>=2)
//  ACC_W  16  accumulator width per lane (>= W+1)
//  LANES  4   parallel weight lanes
//  SAT    0   0: accumulator wraps modulo 2^ACC_W; 1: saturate to range bound
// PORTS
//  clk        in   1            clock, rising edge
//  rstn       in   1            asynchronous active-low reset
//  start      in   1            begin a pass (sampled only in IDLE)
//  clear      in   1            with start: zero accumulators and ovf before the pass
//  sgn        in   1            with start: 1 = two's-complement w and x
//  yi         in   LANES*W      lane weights, lane i = yi[i*W +: W], latched on start
//  yo         out  LANES*W      latched weights, forwarded to the next slice
//  x_bit      in   1            serial activation bit
//  x_valid    in   1            x_bit valid
//  x_ready    out  1            slice accepts x_bit (high only in RUN)
//  acc_out    out  LANES*ACC_W  per-lane accumulator, lane i = acc_out[i*ACC_W +: ACC_W]
//  ovf        out  LANES        per-lane sticky overflow flag
//  out_valid  out  1            acc_out holds a finished pass result
//  out_ready  in   1            consumer takes the result
//  busy       out  1            state != IDLE
// BEHAVIOUR
//  Reset (async, rstn=0): state=IDLE; x_ready, out_valid, busy, acc_out, ovf, yo and the bit counter k all 0.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 latches yi->yo, sgn, clear; if clear, acc=0 and ovf=0. k=0. Next state RUN.
//   RUN: x_ready=1. On a cycle with x_valid & x_ready the bit is accepted; no accept means stall (no state change).
//        Per lane: term = ext(w) << k, where ext = sign-extend if sgn, else zero-extend.
//        acc += term if x_bit; if sgn and k==XBITS-1, acc -= term instead (MSB carries negative weight).
//        k increments per accepted bit. Accepting bit k==XBITS-1 moves to DONE.
//   DONE: out_valid=1; acc_out and ovf are held stable. When out_ready=1, next state is IDLE and out_valid drops.
//  Latency: start edge -> x_ready high next cycle. out_valid rises the cycle after the XBITS-th accepted bit.
//   With no stalls, start to out_valid = XBITS+1 cycles.
//  start outside IDLE is ignored, including the DONE cycle in which out_ready=1. start may be accepted the cycle after.
//  clear=0 on start keeps acc and ovf from the previous pass (partial-sum accumulation).
//  Overflow: each step is evaluated exactly, internally at least ACC_W+W+XBITS+1 bits wide.
//   The valid range is unsigned [0, 2^ACC_W-1] when sgn=0 and signed [-2^(ACC_W-1), 2^(ACC_W-1)-1] when sgn=1.
//   An out-of-range step sets ovf[i] sticky. SAT=0 stores the low ACC_W bits; SAT=1 stores the violated bound.
//  Lanes are fully independent; only x_bit, k and the FSM are shared.
//  x_valid outside RUN is ignored; x_bit is don't-care when x_valid=0.
//  Reset during RUN or DONE aborts the pass immediately. The partial result is discarded (acc=0).
// TESTING (bench params W=4 XBITS=4 ACC_W=8 LANES=2 SAT=0 unless stated)
//  1 unsigned: clear=1, w0=3, w1=5, x=4'b0110 with no stalls -> acc0=18, acc1=30, ovf=0, out_valid 5 cycles after start.
//  2 signed: clear=1, sgn=1, w0=4'b1101(-3), w1=7, x=4'b1110(-2) -> acc0=8'h06, acc1=8'hF2(-14).
//  3 multi-pass: repeat case 1 with clear=0 -> acc0=36, acc1=60. Then start during DONE is ignored.
//  4 stall: case 1 with x_valid low for 3 random cycles -> identical results, out_valid delayed by exactly 3 cycles.
//  5 overflow: w0=15, x=15, pass 1 clear=1 -> 225; pass 2 clear=0 -> 194 (wrap), ovf0=1.
//    Rerun with SAT=1 -> 255, ovf0=1; lane1 (w1=1) -> 30, ovf1=0.
//  6 reset: drop rstn after 2 accepted bits -> all outputs 0 asynchronously, busy=0.
//    A fresh case 1 afterwards gives 18/30.

Source files
------------

// File: rtl/bitblock_n.sv
// bitblock_n: LANES-wide bit-serial MAC slice sharing one LSB-first activation stream
module bitblock_n #(
    parameter int W     = 4,
    parameter int XBITS = 8,
    parameter int ACC_W = 16,
    parameter int LANES = 4,
    parameter int SAT   = 0
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   start,
    input  logic                   clear,
    input  logic                   sgn,
    input  logic [LANES*W-1:0]     yi,
    output logic [LANES*W-1:0]     yo,
    input  logic                   x_bit,
    input  logic                   x_valid,
    output logic                   x_ready,
    output logic [LANES*ACC_W-1:0] acc_out,
    output logic [LANES-1:0]       ovf,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy
);
    localparam int IW = ACC_W + W + XBITS + 2;
    localparam int KW = $clog2(XBITS);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t             state_q, state_d;
    logic [KW-1:0]      k_q, k_d;
    logic               sgn_q, sgn_d;
    logic [LANES*W-1:0] yo_q, yo_d;
    logic               x_ready_q, out_valid_q, busy_q;
    logic               take, last, clr, step;
    assign take      = (state_q == RUN) && x_valid;
    assign last      = k_q == KW'(XBITS - 1);
    assign clr       = (state_q == IDLE) && start && clear;
    assign step      = take && x_bit;
    assign yo        = yo_q;
    assign x_ready   = x_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    // sequencing: latch pass setup on start, count accepted bits, hand off the result
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        sgn_d   = sgn_q;
        yo_d    = yo_q;
        if (state_q == IDLE && start) begin
            state_d = RUN;
            k_d     = '0;
            sgn_d   = sgn;
            yo_d    = yi;
        end
        if (take) begin
            k_d     = k_q + 1'b1;
            state_d = last ? DONE : RUN;
        end
        if (state_q == DONE && out_ready) state_d = IDLE;
    end
    // control state and status outputs, registered from the next state
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            k_q         <= '0;
            sgn_q       <= 1'b0;
            yo_q        <= '0;
            x_ready_q   <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            sgn_q       <= sgn_d;
            yo_q        <= yo_d;
            x_ready_q   <= state_d == RUN;
            out_valid_q <= state_d == DONE;
            busy_q      <= state_d != IDLE;
        end
    end
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [W-1:0]     w;
        logic [ACC_W-1:0] acc_q, acc_d, bound, nxt;
        logic [IW-1:0]    w_ext, a_ext, term, sum;
        logic             ovf_q, ovf_d, oor;
        assign w = yo_q[i*W +: W];
        // exact wide step; the MSB of a signed activation carries negative weight
        always_comb begin
            w_ext = {{(IW-W){w[W-1] & sgn_q}}, w};
            a_ext = {{(IW-ACC_W){acc_q[ACC_W-1] & sgn_q}}, acc_q};
            term  = w_ext << k_q;
            sum   = (sgn_q && last) ? a_ext - term : a_ext + term;
            oor   = sgn_q ? (|sum[IW-1:ACC_W-1] && !(&sum[IW-1:ACC_W-1])) : |sum[IW-1:ACC_W];
            bound = sgn_q ? {sum[IW-1], {(ACC_W-1){~sum[IW-1]}}} : {ACC_W{~sum[IW-1]}};
            nxt   = (SAT != 0 && oor) ? bound : sum[ACC_W-1:0];
            acc_d = clr ? '0 : step ? nxt : acc_q;
            ovf_d = clr ? 1'b0 : step ? (ovf_q | oor) : ovf_q;
        end
        // per-lane accumulator and sticky overflow
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                acc_q <= '0;
                ovf_q <= 1'b0;
            end else begin
                acc_q <= acc_d;
                ovf_q <= ovf_d;
            end
        end
        assign acc_out[i*ACC_W +: ACC_W] = acc_q;
        assign ovf[i]                    = ovf_q;
    end
endmodule

// File: tb/tb_bitblock_n.sv
// tb_bitblock_n: scoreboard bench for bitblock_n in wrap and saturate builds
module tb_bitblock_n;
    logic        clk = 0, rstn = 1, start = 0, clear = 0, sgn = 0;
    logic        x_bit = 0, x_valid = 0, out_ready = 0;
    logic [7:0]  yi = 0;
    logic [7:0]  yo, yo_s;
    logic        x_ready, x_ready_s, out_valid, out_valid_s, busy, busy_s;
    logic [15:0] acc_out, acc_out_s;
    logic [1:0]  ovf, ovf_s;
    int checks = 0, errors = 0;
    typedef struct {
        logic [15:0] acc;
        logic [1:0]  ov;
        int          cyc;
        logic [15:0] acc_s;
        logic [1:0]  ov_s;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    bitblock_n #(.W(4), .XBITS(4), .ACC_W(8), .LANES(2), .SAT(0)) u_dut (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear), .sgn(sgn), .yi(yi), .yo(yo),
        .x_bit(x_bit), .x_valid(x_valid), .x_ready(x_ready), .acc_out(acc_out), .ovf(ovf),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

    bitblock_n #(.W(4), .XBITS(4), .ACC_W(8), .LANES(2), .SAT(1)) u_sat (
        .clk(clk), .rstn(rstn), .start(start), .clear(clear), .sgn(sgn), .yi(yi), .yo(yo_s),
        .x_bit(x_bit), .x_valid(x_valid), .x_ready(x_ready_s), .acc_out(acc_out_s), .ovf(ovf_s),
        .out_valid(out_valid_s), .out_ready(out_ready), .busy(busy_s));

    task automatic run_pass(input logic [7:0] w, input logic [3:0] x, input logic s, input logic c,
                            input int stalls, input logic start_done,
                            output logic [15:0] acc, output logic [15:0] acc_first, output logic [1:0] ov,
                            output logic [15:0] acc_s, output logic [1:0] ov_s,
                            output logic [7:0] yo_seen, output int cyc);
        int sent = 0;
        int left = stalls;
        @(negedge clk);
        yi = w; sgn = s; clear = c; start = 1; x_valid = 1; x_bit = 1;
        @(negedge clk);
        start = 0; clear = 0; yi = ~w; sgn = ~s; cyc = 1;
        while (sent < 4 && cyc < 60) begin
            if (left > 0 && (sent == 3 || $urandom_range(0, 1) == 1)) begin
                x_valid = 0; x_bit = 1; left--;
            end else begin
                x_valid = 1; x_bit = x[sent]; sent++;
            end
            @(negedge clk);
            cyc++;
        end
        x_valid = 1; x_bit = 1;
        while (!out_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        acc_first = acc_out;
        @(negedge clk);
        acc = acc_out; ov = ovf; acc_s = acc_out_s; ov_s = ovf_s; yo_seen = yo;
        x_valid = 0; out_ready = 1; start = start_done;
        @(negedge clk);
        out_ready = 0; start = 0;
    endtask

    task automatic test_reset();
        #1 rstn = 0;
        #1;
        checks++; if ({x_ready, out_valid, busy} !== 3'b000) begin errors++; $display("FAIL reset flags: got %b expected 000", {x_ready, out_valid, busy}); end
        checks++; if (acc_out !== 16'h0) begin errors++; $display("FAIL reset acc: got %h expected 0000", acc_out); end
        checks++; if (ovf !== 2'b00) begin errors++; $display("FAIL reset ovf: got %b expected 00", ovf); end
        checks++; if (yo !== 8'h00) begin errors++; $display("FAIL reset yo: got %h expected 00", yo); end
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle busy: got %b expected 0", busy); end
    endtask

    task automatic test_unsigned();
        logic [15:0] a, af, as; logic [1:0] o, os; logic [7:0] y; int c; exp_t e;
        sb.push_back('{16'h1E12, 2'b00, 5, 16'h1E12, 2'b00});
        run_pass(8'h53, 4'b0110, 1'b0, 1'b1, 0, 1'b0, a, af, o, as, os, y, c);
        e = sb.pop_front();
        checks++; if (af !== e.acc) begin errors++; $display("FAIL unsigned acc_first: got %h expected %h", af, e.acc); end
        checks++; if (a !== e.acc) begin errors++; $display("FAIL unsigned acc_held: got %h expected %h", a, e.acc); end
        checks++; if (o !== e.ov) begin errors++; $display("FAIL unsigned ovf: got %b expected %b", o, e.ov); end
        checks++; if (c !== e.cyc) begin errors++; $display("FAIL unsigned latency: got %0d expected %0d", c, e.cyc); end
        checks++; if (as !== e.acc_s) begin errors++; $display("FAIL unsigned sat acc: got %h expected %h", as, e.acc_s); end
        checks++; if (y !== 8'h53) begin errors++; $display("FAIL unsigned yo: got %h expected 53", y); end
    endtask

    task automatic test_multipass();
        logic [15:0] a, af, as; logic [1:0] o, os; logic [7:0] y; int c; exp_t e;
        sb.push_back('{16'h3C24, 2'b00, 5, 16'h3C24, 2'b00});
        run_pass(8'h53, 4'b0110, 1'b0, 1'b0, 0, 1'b1, a, af, o, as, os, y, c);
        e = sb.pop_front();
        checks++; if (a !== e.acc) begin errors++; $display("FAIL multipass acc: got %h expected %h", a, e.acc); end
        checks++; if (o !== e.ov) begin errors++; $display("FAIL multipass ovf: got %b expected %b", o, e.ov); end
        checks++; if (c !== e.cyc) begin errors++; $display("FAIL multipass latency: got %0d expected %0d", c, e.cyc); end
        checks++; if (as !== e.acc_s) begin errors++; $display("FAIL multipass sat acc: got %h expected %h", as, e.acc_s); end
        checks++; if ({busy, x_ready, out_valid} !== 3'b000) begin errors++; $display("FAIL start_in_done: got %b expected 000", {busy, x_ready, out_valid}); end
    endtask

    task automatic test_signed();
        logic [15:0] a, af, as; logic [1:0] o, os; logic [7:0] y; int c; exp_t e;
        sb.push_back('{16'hF206, 2'b00, 5, 16'hF206, 2'b00});
        run_pass(8'h7D, 4'b1110, 1'b1, 1'b1, 0, 1'b0, a, af, o, as, os, y, c);
        e = sb.pop_front();
        checks++; if (a !== e.acc) begin errors++; $display("FAIL signed acc: got %h expected %h", a, e.acc); end
        checks++; if (o !== e.ov) begin errors++; $display("FAIL signed ovf: got %b expected %b", o, e.ov); end
        checks++; if (c !== e.cyc) begin errors++; $display("FAIL signed latency: got %0d expected %0d", c, e.cyc); end
        checks++; if (as !== e.acc_s) begin errors++; $display("FAIL signed sat acc: got %h expected %h", as, e.acc_s); end
        checks++; if (y !== 8'h7D) begin errors++; $display("FAIL signed yo: got %h expected 7d", y); end
    endtask

    task automatic test_stall();
        logic [15:0] a, af, as; logic [1:0] o, os; logic [7:0] y; int c; exp_t e;
        for (int n = 1; n <= 3; n += 2) begin
            sb.push_back('{16'h1E12, 2'b00, 5 + n, 16'h1E12, 2'b00});
            run_pass(8'h53, 4'b0110, 1'b0, 1'b1, n, 1'b0, a, af, o, as, os, y, c);
            e = sb.pop_front();
            checks++; if (a !== e.acc) begin errors++; $display("FAIL stall%0d acc: got %h expected %h", n, a, e.acc); end
            checks++; if (o !== e.ov) begin errors++; $display("FAIL stall%0d ovf: got %b expected %b", n, o, e.ov); end
            checks++; if (c !== e.cyc) begin errors++; $display("FAIL stall%0d latency: got %0d expected %0d", n, c, e.cyc); end
        end
    endtask

    task automatic test_overflow();
        logic [15:0] a, af, as; logic [1:0] o, os; logic [7:0] y; int c; exp_t e;
        sb.push_back('{16'h0FE1, 2'b00, 5, 16'h0FE1, 2'b00});
        sb.push_back('{16'h1EC2, 2'b01, 5, 16'h1EFF, 2'b01});
        for (int p = 0; p < 2; p++) begin
            run_pass(8'h1F, 4'hF, 1'b0, p == 0, 0, 1'b0, a, af, o, as, os, y, c);
            e = sb.pop_front();
            checks++; if (a !== e.acc) begin errors++; $display("FAIL ovf_pass%0d wrap acc: got %h expected %h", p, a, e.acc); end
            checks++; if (o !== e.ov) begin errors++; $display("FAIL ovf_pass%0d wrap ovf: got %b expected %b", p, o, e.ov); end
            checks++; if (as !== e.acc_s) begin errors++; $display("FAIL ovf_pass%0d sat acc: got %h expected %h", p, as, e.acc_s); end
            checks++; if (os !== e.ov_s) begin errors++; $display("FAIL ovf_pass%0d sat ovf: got %b expected %b", p, os, e.ov_s); end
        end
    endtask

    task automatic test_reset_abort();
        logic [15:0] a, af, as; logic [1:0] o, os; logic [7:0] y; int c; exp_t e;
        @(negedge clk);
        yi = 8'h53; sgn = 0; clear = 1; start = 1;
        @(negedge clk);
        start = 0; clear = 0; x_valid = 1; x_bit = 0;
        @(negedge clk);
        x_bit = 1;
        @(negedge clk);
        x_valid = 0;
        checks++; if (acc_out !== 16'h0A06) begin errors++; $display("FAIL abort partial acc: got %h expected 0a06", acc_out); end
        #2 rstn = 0;
        #1;
        checks++; if ({x_ready, out_valid, busy} !== 3'b000) begin errors++; $display("FAIL abort flags: got %b expected 000", {x_ready, out_valid, busy}); end
        checks++; if (acc_out !== 16'h0) begin errors++; $display("FAIL abort acc: got %h expected 0000", acc_out); end
        checks++; if ({ovf, yo} !== 10'h0) begin errors++; $display("FAIL abort ovf_yo: got %h expected 000", {ovf, yo}); end
        @(negedge clk);
        rstn = 1;
        sb.push_back('{16'h1E12, 2'b00, 5, 16'h1E12, 2'b00});
        run_pass(8'h53, 4'b0110, 1'b0, 1'b0, 0, 1'b0, a, af, o, as, os, y, c);
        e = sb.pop_front();
        checks++; if (a !== e.acc) begin errors++; $display("FAIL after_abort acc: got %h expected %h", a, e.acc); end
        checks++; if (o !== e.ov) begin errors++; $display("FAIL after_abort ovf: got %b expected %b", o, e.ov); end
        checks++; if (c !== e.cyc) begin errors++; $display("FAIL after_abort latency: got %0d expected %0d", c, e.cyc); end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_multipass();
        test_signed();
        test_stall();
        test_overflow();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end
endmodule
